// File: rtl/trng_word_collector.sv
// Ring-oscillator TRNG sampler: warm-up, repetition-count health test, LSB-first word packing.
// Define TRNG_DEBIAS_EN to insert von Neumann debiasing on the accepted-bit path.
module trng_word_collector #(
    parameter int unsigned WORD_WIDTH    = 32,
    parameter int unsigned WARMUP_CYCLES = 8,
    parameter int unsigned REP_LIMIT     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  trng_in,
    output logic                  trng_en,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic                  valid,
    input  logic                  ready,
    output logic                  health_fail,
    input  logic                  clear_fail
);

    localparam int unsigned BW = $clog2(WORD_WIDTH + 1);
    localparam int unsigned WW = $clog2(WARMUP_CYCLES + 1);
    localparam int unsigned RW = $clog2(REP_LIMIT + 1);
    localparam logic [BW-1:0] LastBit  = BW'(WORD_WIDTH - 1);
    localparam logic [WW-1:0] LastWarm = WW'(WARMUP_CYCLES - 1);
    localparam logic [RW-1:0] RepMax   = RW'(REP_LIMIT);

    typedef enum logic [2:0] {StIdle, StWarmup, StCollect, StFull, StFail} state_e;

    state_e                  state_q, state_d;
    logic [WW-1:0]           warm_q, warm_d;
    logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [WORD_WIDTH-1:0]   shift_q, shift_d;
    logic [RW-1:0]           rep_q, rep_d;
    logic                    prev_q, prev_d;
    logic [WORD_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    fail_q, fail_d;
    logic                    trng_en_q, trng_en_d;
    logic                    accept, acc_bit, load_word;
    logic [WORD_WIDTH-1:0]   word_next;
`ifdef TRNG_DEBIAS_EN
    logic                    phase_q, phase_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            warm_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            rep_q     <= '0;
            prev_q    <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            fail_q    <= 1'b0;
            trng_en_q <= 1'b0;
`ifdef TRNG_DEBIAS_EN
            phase_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            warm_q    <= warm_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rep_q     <= rep_d;
            prev_q    <= prev_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            fail_q    <= fail_d;
            trng_en_q <= trng_en_d;
`ifdef TRNG_DEBIAS_EN
            phase_q   <= phase_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        warm_d    = warm_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        rep_d     = rep_q;
        prev_d    = prev_q;
        accept    = 1'b0;
        acc_bit   = 1'b0;
        load_word = 1'b0;
        word_next = shift_q;
`ifdef TRNG_DEBIAS_EN
        phase_d   = phase_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d   = StWarmup;
                    warm_d    = '0;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            StWarmup: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (warm_q == LastWarm) begin
                    state_d = StCollect;
                    rep_d   = '0;
`ifdef TRNG_DEBIAS_EN
                    phase_d = 1'b0;
`endif
                end else begin
                    warm_d = warm_q + 1'b1;
                end
            end
            StCollect: begin
                if (!enable) begin
                    state_d   = StIdle;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end else begin
                    prev_d = trng_in;
                    // rep_q == 0 marks the first sample since entering COLLECT
                    if (rep_q == '0 || trng_in != prev_q) begin
                        rep_d = RW'(1);
                    end else if (rep_q != RepMax) begin
                        rep_d = rep_q + 1'b1;
                    end
`ifdef TRNG_DEBIAS_EN
                    // Second sample of a pair: prev_q holds the first one
                    phase_d = ~phase_q;
                    if (phase_q && (trng_in != prev_q)) begin
                        accept  = 1'b1;
                        acc_bit = prev_q;
                    end
`else
                    accept  = 1'b1;
                    acc_bit = trng_in;
`endif
                    word_next = shift_q | (WORD_WIDTH'(acc_bit) << bit_cnt_q);
                    if (accept) begin
                        shift_d   = word_next;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    if (rep_d == RepMax) begin
                        state_d   = StFail;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end else if (accept && bit_cnt_q == LastBit) begin
                        state_d   = StFull;
                        load_word = 1'b1;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end
                end
            end
            StFull: begin
                if (ready) begin
                    state_d = enable ? StCollect : StIdle;
                    rep_d   = '0;
`ifdef TRNG_DEBIAS_EN
                    phase_d = 1'b0;
`endif
                end
            end
            StFail: begin
                if (clear_fail) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered: decode them from the next state
    always_comb begin
        trng_en_d = (state_d == StWarmup) || (state_d == StCollect) || (state_d == StFull);
        valid_d   = (state_d == StFull);
        fail_d    = (state_d == StFail);
        data_d    = load_word ? word_next : data_q;
    end

    assign trng_en     = trng_en_q;
    assign data_o      = data_q;
    assign valid       = valid_q;
    assign health_fail = fail_q;

endmodule

// File: tb/tb_trng_word_collector.sv
// Directed bench for trng_word_collector with default parameters.
// Compile with TRNG_DEBIAS_EN to exercise the debiasing word patterns.
module tb_trng_word_collector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        trng_in = 1'b0;
    logic        ready = 1'b0;
    logic        clear_fail = 1'b0;
    logic        trng_en;
    logic        valid;
    logic        health_fail;
    logic [31:0] data_o;

    int checks = 0;
    int errors = 0;

    trng_word_collector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .trng_in    (trng_in),
        .trng_en    (trng_en),
        .data_o     (data_o),
        .valid      (valid),
        .ready      (ready),
        .health_fail(health_fail),
        .clear_fail (clear_fail)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one raw sample for the coming edge, then settle just after it
    task automatic tick(input logic b);
        trng_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [31:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) tick(w[i]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        #12;
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_data", data_o, 32'd0);
        chk("rst_fail", {31'd0, health_fail}, 32'd0);
        chk("rst_en", {31'd0, trng_en}, 32'd0);

        rst_n  = 1'b1;
        enable = 1'b1;
        ready  = 1'b1;
        tick(1'b0);
        chk("warmup_en", {31'd0, trng_en}, 32'd1);
        repeat (8) tick(1'b1);
        chk("warmup_novalid", {31'd0, valid}, 32'd0);

`ifdef TRNG_DEBIAS_EN
        for (int p = 0; p < 31; p++) begin tick(1'b1); tick(1'b0); end
        tick(1'b1);
        chk("db10_early", {31'd0, valid}, 32'd0);
        tick(1'b0);
        chk("db10_valid", {31'd0, valid}, 32'd1);
        chk("db10_data", data_o, 32'hFFFF_FFFF);
        tick(1'b0);
        chk("db_xfer1", {31'd0, valid}, 32'd0);
        for (int p = 0; p < 32; p++) begin tick(1'b0); tick(1'b1); end
        chk("db01_valid", {31'd0, valid}, 32'd1);
        chk("db01_data", data_o, 32'h0000_0000);
        tick(1'b0);
        chk("db_xfer2", {31'd0, valid}, 32'd0);
        for (int p = 0; p < 31; p++) begin tick(1'b1); tick(1'b1); tick(1'b1); tick(1'b0); end
        tick(1'b1); tick(1'b1); tick(1'b1);
        chk("db1110_early", {31'd0, valid}, 32'd0);
        tick(1'b0);
        chk("db1110_valid", {31'd0, valid}, 32'd1);
        chk("db1110_data", data_o, 32'hFFFF_FFFF);
`else
        for (int i = 0; i < 31; i++) tick((i % 2) == 0);
        chk("alt_early", {31'd0, valid}, 32'd0);
        tick(1'b0);
        chk("alt_valid", {31'd0, valid}, 32'd1);
        chk("alt_data", data_o, 32'h5555_5555);
        tick(1'b0);
        chk("alt_one_cycle", {31'd0, valid}, 32'd0);

        w = 32'hA5C3_0F96;
        feed(w, 32);
        chk("bp_valid", {31'd0, valid}, 32'd1);
        chk("bp_data", data_o, w);
        ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1'($urandom_range(1, 0)));
            chk("bp_hold_valid", {31'd0, valid}, 32'd1);
            chk("bp_hold_data", data_o, w);
        end
        ready = 1'b1;
        tick(1'b0);
        chk("bp_xfer", {31'd0, valid}, 32'd0);
        w = 32'h3C69_E1D2;
        feed(w, 31);
        chk("w3_early", {31'd0, valid}, 32'd0);
        tick(w[31]);
        chk("w3_valid", {31'd0, valid}, 32'd1);
        chk("w3_data", data_o, w);
`endif

        // Asynchronous reset while a word is held in FULL
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, valid}, 32'd0);
        chk("arst_data", data_o, 32'd0);
        chk("arst_fail", {31'd0, health_fail}, 32'd0);
        chk("arst_en", {31'd0, trng_en}, 32'd0);
        enable = 1'b0;
        rst_n  = 1'b1;
        tick(1'b0);
        chk("arst_idle_en", {31'd0, trng_en}, 32'd0);

        // Repetition-count failure on a stuck-at-1 source
        enable = 1'b1;
        tick(1'b0);
        repeat (8) tick(1'b0);
        repeat (15) tick(1'b1);
        chk("rep15_nofail", {31'd0, health_fail}, 32'd0);
        tick(1'b1);
        chk("rep16_fail", {31'd0, health_fail}, 32'd1);
        chk("rep16_en", {31'd0, trng_en}, 32'd0);
        chk("rep16_valid", {31'd0, valid}, 32'd0);
        repeat (3) tick(1'b0);
        chk("fail_sticky", {31'd0, health_fail}, 32'd1);
        clear_fail = 1'b1;
        enable     = 1'b0;
        tick(1'b0);
        clear_fail = 1'b0;
        chk("clear_fail", {31'd0, health_fail}, 32'd0);
        chk("clear_en", {31'd0, trng_en}, 32'd0);

`ifndef TRNG_DEBIAS_EN
        // Failing sample is also the 32nd bit: failure must win
        enable = 1'b1;
        tick(1'b0);
        repeat (8) tick(1'b0);
        for (int i = 0; i < 16; i++) tick((i % 2) == 0);
        repeat (15) tick(1'b1);
        chk("tie_pre_fail", {31'd0, health_fail}, 32'd0);
        tick(1'b1);
        chk("tie_fail", {31'd0, health_fail}, 32'd1);
        chk("tie_valid", {31'd0, valid}, 32'd0);
        clear_fail = 1'b1;
        enable     = 1'b0;
        tick(1'b0);
        clear_fail = 1'b0;

        // Enable dropped mid-word, then a full fresh collection
        enable = 1'b1;
        tick(1'b0);
        repeat (8) tick(1'b1);
        repeat (10) tick(1'b1);
        enable = 1'b0;
        tick(1'b1);
        chk("drop_en", {31'd0, trng_en}, 32'd0);
        chk("drop_valid", {31'd0, valid}, 32'd0);
        enable = 1'b1;
        tick(1'b1);
        chk("reen_en", {31'd0, trng_en}, 32'd1);
        repeat (8) tick(1'b1);
        w = 32'h1234_5678;
        feed(w, 31);
        chk("fresh_early", {31'd0, valid}, 32'd0);
        tick(w[31]);
        chk("fresh_valid", {31'd0, valid}, 32'd1);
        chk("fresh_data", data_o, w);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
